// File: rtl/updown_counter_ext.sv
// Parametrised up/down event/position counter with programmable bounds, step,
// parallel load, per-cycle saturate/wrap selection and overflow/underflow pulses.
module updown_counter_ext #(
   parameter int WIDTH  = 8,
   parameter int STEP_W = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EN,
   input  logic              UP_DWN,
   input  logic              WRAP,
   input  logic [STEP_W-1:0] STEP,
   input  logic              LOAD,
   input  logic [WIDTH-1:0]  LOAD_VAL,
   input  logic [WIDTH-1:0]  MIN_VAL,
   input  logic [WIDTH-1:0]  MAX_VAL,
   output logic [WIDTH-1:0]  COUNT,
   output logic              AT_MAX,
   output logic              AT_MIN,
   output logic              OVF,
   output logic              UNF
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             ovf_q;
   logic             ovf_d;
   logic             unf_q;
   logic             unf_d;
   logic [WIDTH:0]   step_ext;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic             up_fits;
   logic             down_fits;

   // The extra top bit keeps carries out of 2^WIDTH-1 and borrows below 0 visible.
   assign step_ext  = (WIDTH+1)'(STEP);
   assign sum       = {1'b0, count_q} + step_ext;
   assign diff      = {1'b0, count_q} - step_ext;
   assign up_fits   = (sum <= {1'b0, MAX_VAL});
   assign down_fits = !diff[WIDTH] && (diff[WIDTH-1:0] >= MIN_VAL);

   always_comb begin
      count_d = count_q;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      if (LOAD) begin
         if (LOAD_VAL < MIN_VAL)
            count_d = MIN_VAL;
         else if (LOAD_VAL > MAX_VAL)
            count_d = MAX_VAL;
         else
            count_d = LOAD_VAL;
      end else if (count_q < MIN_VAL) begin
         count_d = MIN_VAL;
      end else if (count_q > MAX_VAL) begin
         count_d = MAX_VAL;
      end else if (EN) begin
         if (UP_DWN) begin
            if (up_fits) begin
               count_d = sum[WIDTH-1:0];
            end else if (WRAP) begin
               count_d = MIN_VAL;
               ovf_d   = 1'b1;
            end else begin
               count_d = MAX_VAL;
               ovf_d   = (count_q != MAX_VAL);
            end
         end else begin
            if (down_fits) begin
               count_d = diff[WIDTH-1:0];
            end else if (WRAP) begin
               count_d = MAX_VAL;
               unf_d   = 1'b1;
            end else begin
               count_d = MIN_VAL;
               unf_d   = (count_q != MIN_VAL);
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign COUNT  = count_q;
   assign OVF    = ovf_q;
   assign UNF    = unf_q;
   assign AT_MAX = (count_q == MAX_VAL);
   assign AT_MIN = (count_q == MIN_VAL);

endmodule

// File: tb/tb_updown_counter_ext.sv
// Self-checking bench for updown_counter_ext: directed scenarios with literal
// expectations, then random traffic compared every cycle against an integer model.
module tb_updown_counter_ext;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       EN = 1'b0;
   logic       UP_DWN = 1'b0;
   logic       WRAP = 1'b0;
   logic [3:0] STEP = 4'd0;
   logic       LOAD = 1'b0;
   logic [7:0] LOAD_VAL = 8'd0;
   logic [7:0] MIN_VAL = 8'd0;
   logic [7:0] MAX_VAL = 8'd255;
   logic [7:0] COUNT;
   logic       AT_MAX;
   logic       AT_MIN;
   logic       OVF;
   logic       UNF;

   int  assertCount = 0;
   int  failCount = 0;
   bit  checkEnable = 1'b0;
   int  modelCount = 0;
   bit  modelOvf = 1'b0;
   bit  modelUnf = 1'b0;

   updown_counter_ext #(.WIDTH(8), .STEP_W(4)) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .UP_DWN(UP_DWN), .WRAP(WRAP),
      .STEP(STEP), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .MIN_VAL(MIN_VAL),
      .MAX_VAL(MAX_VAL), .COUNT(COUNT), .AT_MAX(AT_MAX), .AT_MIN(AT_MIN),
      .OVF(OVF), .UNF(UNF)
   );

   always #5 CLK = ~CLK;

   // Reference behaviour in plain integers: bounds are inclusive, out-of-range
   // results either stick to the crossed bound or jump to the opposite one.
   function automatic void modelNext(input int c, input bit rst, input bit load,
                                     input int lv, input bit en, input bit up,
                                     input bit wrap, input int s, input int mn,
                                     input int mx, output int nc, output bit o,
                                     output bit u);
      nc = c;
      o  = 1'b0;
      u  = 1'b0;
      if (rst)
         nc = 0;
      else if (load)
         nc = (lv < mn) ? mn : ((lv > mx) ? mx : lv);
      else if (c < mn)
         nc = mn;
      else if (c > mx)
         nc = mx;
      else if (en && s != 0) begin
         if (up) begin
            if (c + s <= mx)
               nc = c + s;
            else if (wrap) begin
               nc = mn;
               o  = 1'b1;
            end else begin
               o  = (c != mx);
               nc = mx;
            end
         end else begin
            if (c - s >= mn)
               nc = c - s;
            else if (wrap) begin
               nc = mx;
               u  = 1'b1;
            end else begin
               u  = (c != mn);
               nc = mn;
            end
         end
      end
   endfunction

   always @(posedge CLK) begin
      int nc;
      bit o;
      bit u;
      modelNext(modelCount, RST, LOAD, int'(LOAD_VAL), EN, UP_DWN, WRAP,
                int'(STEP), int'(MIN_VAL), int'(MAX_VAL), nc, o, u);
      modelCount <= nc;
      modelOvf   <= o;
      modelUnf   <= u;
   end

   // Per-cycle comparison against the model, mid-cycle away from the active edge.
   always @(negedge CLK) begin
      if (checkEnable) begin
         assertCount++;
         if (int'(COUNT) != modelCount) begin
            failCount++;
            $display("[TB] FAIL model COUNT: got %0d expected %0d at %0t", COUNT, modelCount, $time);
         end
         assertCount++;
         if (OVF !== modelOvf || UNF !== modelUnf) begin
            failCount++;
            $display("[TB] FAIL model OVF/UNF: got %b/%b expected %b/%b at %0t", OVF, UNF, modelOvf, modelUnf, $time);
         end
         assertCount++;
         if (AT_MAX !== (modelCount == int'(MAX_VAL)) || AT_MIN !== (modelCount == int'(MIN_VAL))) begin
            failCount++;
            $display("[TB] FAIL model AT_MAX/AT_MIN: got %b/%b expected %b/%b at %0t", AT_MAX, AT_MIN,
                     modelCount == int'(MAX_VAL), modelCount == int'(MIN_VAL), $time);
         end
         assertCount++;
         if (OVF === 1'b1 && UNF === 1'b1) begin
            failCount++;
            $display("[TB] FAIL exclusive pulses: got OVF=1 UNF=1 expected not both at %0t", $time);
         end
      end
   end

   task automatic applyStimulus(input bit rst, input bit load, input int lv, input bit en,
                                input bit up, input bit wrap, input int s, input int mn,
                                input int mx);
      RST      = rst;
      LOAD     = load;
      LOAD_VAL = 8'(lv);
      EN       = en;
      UP_DWN   = up;
      WRAP     = wrap;
      STEP     = 4'(s);
      MIN_VAL  = 8'(mn);
      MAX_VAL  = 8'(mx);
      @(posedge CLK);
      #1;
   endtask

   task automatic checkOutput(input string name, input int expCount, input bit expOvf,
                              input bit expUnf);
      assertCount++;
      if (int'(COUNT) != expCount || OVF !== expOvf || UNF !== expUnf) begin
         failCount++;
         $display("[TB] FAIL %s: got COUNT=%0d OVF=%b UNF=%b expected COUNT=%0d OVF=%b UNF=%b",
                  name, COUNT, OVF, UNF, expCount, expOvf, expUnf);
      end
   endtask

   initial begin
      int mn;
      int mx;
      int t;
      bit ld;

      // Reset wins over load and enable.
      applyStimulus(1, 1, 8'h55, 1, 1, 0, 1, 0, 255);
      checkEnable = 1'b1;
      applyStimulus(1, 1, 8'h55, 1, 1, 0, 1, 0, 255);
      checkOutput("reset priority", 0, 0, 0);
      applyStimulus(0, 1, 8'h55, 1, 1, 0, 1, 0, 255);
      checkOutput("load after reset", 8'h55, 0, 0);

      // Saturating up count.
      applyStimulus(0, 1, 195, 0, 1, 0, 7, 10, 200);
      checkOutput("load 195", 195, 0, 0);
      applyStimulus(0, 0, 0, 1, 1, 0, 7, 10, 200);
      checkOutput("saturate up", 200, 1, 0);
      applyStimulus(0, 0, 0, 1, 1, 0, 7, 10, 200);
      checkOutput("saturate hold", 200, 0, 0);
      assertCount++;
      if (AT_MAX !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL at_max literal: got %b expected 1", AT_MAX);
      end

      // Wrapping down count.
      applyStimulus(0, 1, 12, 0, 0, 1, 4, 10, 200);
      applyStimulus(0, 0, 0, 1, 0, 1, 4, 10, 200);
      checkOutput("wrap down", 200, 0, 1);
      applyStimulus(0, 0, 0, 1, 0, 1, 4, 10, 200);
      checkOutput("after wrap down", 196, 0, 0);

      // Full-range edges where the raw sum/difference leaves 8 bits.
      applyStimulus(0, 1, 250, 0, 1, 1, 15, 0, 255);
      applyStimulus(0, 0, 0, 1, 1, 1, 15, 0, 255);
      checkOutput("full wrap up", 0, 1, 0);
      applyStimulus(0, 1, 3, 0, 0, 0, 15, 0, 255);
      applyStimulus(0, 0, 0, 1, 0, 0, 15, 0, 255);
      checkOutput("full saturate down", 0, 0, 1);
      applyStimulus(0, 0, 0, 1, 0, 0, 15, 0, 255);
      checkOutput("pinned at zero", 0, 0, 0);

      // Bounds moving under the count.
      applyStimulus(0, 1, 150, 0, 1, 0, 1, 0, 255);
      applyStimulus(0, 0, 0, 0, 1, 0, 1, 0, 100);
      checkOutput("clamp to new max", 100, 0, 0);
      applyStimulus(0, 1, 5, 0, 1, 0, 1, 10, 100);
      checkOutput("load clamp to min", 10, 0, 0);

      // Holds.
      applyStimulus(0, 1, 77, 0, 1, 0, 1, 0, 255);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 0, 0, i[0], i[1], i[2], i[0] ? 0 : 5, 0, 255);
         checkOutput("hold", 77, 0, 0);
      end

      // Degenerate single-value range in wrap mode.
      applyStimulus(0, 1, 77, 0, 1, 1, 1, 42, 42);
      checkOutput("load pinned", 42, 0, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 1, 1, 1, 1, 42, 42);
         checkOutput("pinned wrap up", 42, 1, 0);
      end

      // Random traffic, bounds always kept ordered.
      mn = 10;
      mx = 200;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            mn = $urandom_range(0, 255);
            mx = $urandom_range(0, 255);
            if ($urandom_range(0, 5) == 0) mx = mn;
            if ($urandom_range(0, 7) == 0) begin
               mn = 0;
               mx = 255;
            end
            if (mn > mx) begin
               t  = mn;
               mn = mx;
               mx = t;
            end
         end
         ld = ($urandom_range(0, 15) == 0);
         applyStimulus($urandom_range(0, 99) == 0, ld, $urandom_range(0, 255),
                       $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 1) == 1, $urandom_range(0, 15), mn, mx);
      end

      @(negedge CLK);
      checkEnable = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
